jtag_shift_out_packer: RTL and testbench

JTAG_SHIFT_OUT_PACKER -- requirements
Module: jtag_shift_out_packer

---
 rtl/jtag_shift_out_packer.sv | 119 +++++++++++
 tb/tb_jtag_shift_out_packer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_shift_out_packer.sv
// Purpose : packs a JTAG serial bit stream LSB-first into DATA_WIDTH words for a FIFO write port,
//           tags frame ends and reports the (saturating) bit length of every completed frame.
// Latency : a completed word appears in the hold register one cycle after its final bit is accepted.
// Backpr. : s_ready drops only while the hold register is full and the FIFO reports wfull.
//
// Ports:
//   wclk, wrst                 write-domain clock, asynchronous active-high reset
//   s_valid/s_bit/s_last       serial bit offer (s_last marks the final bit of a frame)
//   s_ready                    offered bit is accepted this cycle
//   wfull, w_en, wdata, wlast  FIFO write side (wlast stored with wdata)
//   frame_bits, frame_done     length of last completed frame, one-cycle completion pulse
module jtag_shift_out_packer #(
  parameter int DATA_WIDTH      = 32,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       wclk,
  input  logic                       wrst,
  input  logic                       s_valid,
  input  logic                       s_bit,
  input  logic                       s_last,
  output logic                       s_ready,
  input  logic                       wfull,
  output logic                       w_en,
  output logic [DATA_WIDTH-1:0]      wdata,
  output logic                       wlast,
  output logic [FRAME_CNT_WIDTH-1:0] frame_bits,
  output logic                       frame_done
);

  localparam int CW = $clog2(DATA_WIDTH);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  localparam logic [CW-1:0]              CNT_MAX  = CW'(DATA_WIDTH - 1);
  localparam logic [FRAME_CNT_WIDTH-1:0] FCNT_MAX = '1;

  logic [DATA_WIDTH-1:0]      shreg;
  logic [DATA_WIDTH-1:0]      shreg_nxt;
  logic [DATA_WIDTH-1:0]      bit_mask;
  logic [CW-1:0]              cnt;
  logic [DATA_WIDTH-1:0]      hold_dat;
  logic                       hold_last;
  logic                       hold_vld;
  logic [0:0]                 state;
  logic [0:0]                 state_nxt;
  logic [FRAME_CNT_WIDTH-1:0] fcnt;
  logic [FRAME_CNT_WIDTH-1:0] fcnt_inc;
  logic                       accept;
  logic                       word_done;

  // A full hold register may still accept a completing word when the FIFO
  // is not full: it drains and reloads in the same cycle.
  assign s_ready   = ~hold_vld | ~wfull;
  assign accept    = s_valid & s_ready;
  assign word_done = accept & (s_last | (cnt == CNT_MAX));

  assign bit_mask  = {{(DATA_WIDTH-1){1'b0}}, s_bit} << cnt;
  assign shreg_nxt = shreg | bit_mask;

  // Saturating frame length including the bit being accepted.
  assign fcnt_inc  = (fcnt == FCNT_MAX) ? fcnt : fcnt + 1'b1;

  assign w_en  = hold_vld & ~wfull;
  assign wdata = hold_dat;
  assign wlast = hold_last;

  // A 1-bit frame (s_last while IDLE) leaves the FSM in IDLE.
  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = s_last ? IDLE : ACTIVE;
    end
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      hold_dat   <= '0;
      hold_last  <= 1'b0;
      hold_vld   <= 1'b0;
      fcnt       <= '0;
      frame_bits <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= accept & s_last;

      if (accept) begin
        if (word_done) begin
          shreg <= '0;
          cnt   <= '0;
        end else begin
          shreg <= shreg_nxt;
          cnt   <= cnt + 1'b1;
        end

        if (s_last) begin
          frame_bits <= fcnt_inc;
          fcnt       <= '0;
        end else begin
          fcnt <= fcnt_inc;
        end
      end

      // Reload wins over drain so back-to-back words keep hold_vld high.
      if (word_done) begin
        hold_dat  <= shreg_nxt;
        hold_last <= s_last;
        hold_vld  <= 1'b1;
      end else if (w_en) begin
        hold_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jtag_shift_out_packer.sv
// Bench for jtag_shift_out_packer: directed scenarios plus random frames with
// random valid gaps and FIFO-full stalls, compared against a frame-level model.
module tb_jtag_shift_out_packer;

  localparam int DW = 32;
  localparam int FW = 16;
  localparam int FMAX = 65535;

  logic          wclk;
  logic          wrst;
  logic          s_valid;
  logic          s_bit;
  logic          s_last;
  logic          s_ready;
  logic          wfull;
  logic          w_en;
  logic [DW-1:0] wdata;
  logic          wlast;
  logic [FW-1:0] frame_bits;
  logic          frame_done;

  jtag_shift_out_packer #(.DATA_WIDTH(DW), .FRAME_CNT_WIDTH(FW)) dut (
    .wclk       (wclk),
    .wrst       (wrst),
    .s_valid    (s_valid),
    .s_bit      (s_bit),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .wfull      (wfull),
    .w_en       (w_en),
    .wdata      (wdata),
    .wlast      (wlast),
    .frame_bits (frame_bits),
    .frame_done (frame_done)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int checks = 0;
  int errors = 0;

  // Reference model: expected FIFO writes {wlast, wdata} and frame lengths.
  logic [DW:0]   expw[$];
  int            expf[$];
  logic [DW-1:0] word_acc;
  int            word_idx;
  int            frame_pos;
  int            wen_cnt;
  bit            rand_full;
  bit            gaps;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: every FIFO write and frame_done pulse must match the model in order.
  always @(negedge wclk) begin
    logic [DW:0] e;
    int          ef;
    if (!wrst) begin
      if (wfull) check("wen_while_full", 64'(w_en), 64'd0);
      if (w_en) begin
        wen_cnt++;
        check("wen_expected", 64'(expw.size() > 0), 64'd1);
        if (expw.size() > 0) begin
          e = expw.pop_front();
          check("wdata", 64'(wdata), 64'(e[DW-1:0]));
          check("wlast", 64'(wlast), 64'(e[DW]));
        end
      end
      if (frame_done) begin
        check("frame_done_expected", 64'(expf.size() > 0), 64'd1);
        if (expf.size() > 0) begin
          ef = expf.pop_front();
          check("frame_bits", 64'(frame_bits), 64'(ef));
        end
      end
    end
  end

  task automatic step();
    @(posedge wclk);
    #1;
    if (rand_full) wfull = ($urandom_range(0, 3) == 0);
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (n) step();
  endtask

  task automatic model_bit(input logic b, input logic last);
    word_acc[word_idx] = b;
    word_idx++;
    frame_pos++;
    if (word_idx == DW || last) begin
      expw.push_back({last, word_acc});
      word_acc = '0;
      word_idx = 0;
    end
    if (last) begin
      expf.push_back(frame_pos > FMAX ? FMAX : frame_pos);
      frame_pos = 0;
    end
  endtask

  task automatic send_bit(input logic b, input logic last);
    bit acc;
    int waited;
    s_valid = 1'b1;
    s_bit   = b;
    s_last  = last;
    waited  = 0;
    acc     = 1'b0;
    while (!acc && waited < 500) begin
      @(negedge wclk);
      acc = s_ready;
      step();
      if (!acc) waited++;
    end
    if (acc) model_bit(b, last);
    else check("accept_timeout", 64'(waited), 64'd0);
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
  endtask

  // mode 0: random bits, 1: all ones, 2: alternating starting with 1
  task automatic send_bits(input int n, input int mode, input bit last_on_end);
    logic b;
    for (int i = 0; i < n; i++) begin
      case (mode)
        1:       b = 1'b1;
        2:       b = (i % 2 == 0);
        default: b = 1'($urandom_range(0, 1));
      endcase
      send_bit(b, last_on_end && (i == n - 1));
    end
  endtask

  task automatic reset_dut();
    @(posedge wclk);
    #1;
    wrst = 1'b1;
    expw.delete();
    expf.delete();
    word_acc  = '0;
    word_idx  = 0;
    frame_pos = 0;
    @(negedge wclk);
    check("rst_w_en", 64'(w_en), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    @(posedge wclk);
    #1;
    wrst = 1'b0;
  endtask

  initial begin
    wrst      = 1'b1;
    s_valid   = 1'b0;
    s_bit     = 1'b0;
    s_last    = 1'b0;
    wfull     = 1'b0;
    rand_full = 1'b0;
    gaps      = 1'b0;
    word_acc  = '0;
    word_idx  = 0;
    frame_pos = 0;
    wen_cnt   = 0;

    // Reset state
    @(negedge wclk);
    check("reset_w_en", 64'(w_en), 64'd0);
    check("reset_wdata", 64'(wdata), 64'd0);
    check("reset_wlast", 64'(wlast), 64'd0);
    check("reset_frame_done", 64'(frame_done), 64'd0);
    check("reset_frame_bits", 64'(frame_bits), 64'd0);
    check("reset_s_ready", 64'(s_ready), 64'd1);
    wfull = 1'b1;
    #1;
    check("reset_w_en_full", 64'(w_en), 64'd0);
    wfull = 1'b0;
    @(posedge wclk);
    #1;
    wrst = 1'b0;

    // 32 alternating bits, frame still open
    wen_cnt = 0;
    send_bits(32, 2, 1'b0);
    idle(4);
    check("alt_wen_cnt", 64'(wen_cnt), 64'd1);
    check("alt_pending", 64'(expw.size()), 64'd0);

    // Reset mid-frame after 10 bits, then a 3-bit frame of ones
    send_bits(10, 0, 1'b0);
    reset_dut();
    wen_cnt = 0;
    send_bits(3, 1, 1'b1);
    idle(4);
    check("rst_frame_wen_cnt", 64'(wen_cnt), 64'd1);
    check("rst_frame_pending", 64'(expf.size()), 64'd0);

    // 5 ones, 1-word frame
    wen_cnt = 0;
    send_bits(5, 1, 1'b1);
    idle(4);
    check("five_wen_cnt", 64'(wen_cnt), 64'd1);

    // 64-bit frame: no trailing empty word
    wen_cnt = 0;
    send_bits(64, 0, 1'b1);
    idle(4);
    check("f64_wen_cnt", 64'(wen_cnt), 64'd2);
    check("f64_pending", 64'(expw.size()), 64'd0);

    // FIFO full while a word completes, second word stalls until release
    wen_cnt = 0;
    wfull   = 1'b1;
    send_bits(DW, 0, 1'b0);
    s_valid = 1'b1;
    s_bit   = 1'b1;
    repeat (3) begin
      @(negedge wclk);
      check("stall_s_ready", 64'(s_ready), 64'd0);
      check("stall_w_en", 64'(w_en), 64'd0);
      @(posedge wclk);
      #1;
    end
    s_valid = 1'b0;
    wfull   = 1'b0;
    send_bits(DW, 0, 1'b1);
    idle(4);
    check("stall_wen_cnt", 64'(wen_cnt), 64'd2);
    check("stall_pending", 64'(expw.size()), 64'd0);

    // Reset discards an undrained hold word
    wfull = 1'b1;
    send_bits(DW, 0, 1'b0);
    idle(2);
    reset_dut();
    wen_cnt = 0;
    wfull   = 1'b0;
    idle(5);
    check("discard_wen_cnt", 64'(wen_cnt), 64'd0);

    // Random frames with valid gaps and random FIFO-full
    rand_full = 1'b1;
    gaps      = 1'b1;
    repeat (25) send_bits($urandom_range(1, 100), 0, 1'b1);
    rand_full = 1'b0;
    gaps      = 1'b0;
    wfull     = 1'b0;
    idle(8);
    check("rand_pending_words", 64'(expw.size()), 64'd0);
    check("rand_pending_frames", 64'(expf.size()), 64'd0);

    // Long frame: frame counter saturates
    wen_cnt = 0;
    send_bits(70000, 0, 1'b1);
    idle(4);
    check("long_wen_cnt", 64'(wen_cnt), 64'd2188);
    check("long_pending_words", 64'(expw.size()), 64'd0);
    check("long_pending_frames", 64'(expf.size()), 64'd0);
    check("long_frame_bits", 64'(frame_bits), 64'd65535);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
